// File: rtl/trace_sequencer.sv
// Replays per-channel ASCII waveform strings ('-' = 1, else 0), one character per enabled clock.
// Optional TRACE_SEQ_EDGE_EN adds rose/fell outputs referenced to the previous cycle's sig.
module trace_sequencer #(
    parameter int CHANNELS = 4,
    parameter int LENGTH   = 32,
    parameter int LOOP     = 0,
    parameter logic [8*CHANNELS*LENGTH-1:0] TRACES = {CHANNELS*LENGTH{"_"}},
    localparam int T_W = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic [CHANNELS-1:0] sig,
    output logic [T_W-1:0]      t,
    output logic                done,
    output logic [7:0]          wraps
`ifdef TRACE_SEQ_EDGE_EN
    ,
    output logic [CHANNELS-1:0] rose,
    output logic [CHANNELS-1:0] fell
`endif
);

    localparam logic [T_W-1:0] LAST = T_W'(LENGTH - 1);

    logic [T_W-1:0]      t_q, t_d;
    logic [7:0]          wraps_q, wraps_d;
    logic [CHANNELS-1:0] sig_c;

    always_comb begin
        t_d     = t_q;
        wraps_d = wraps_q;
        if (enable) begin
            if (t_q != LAST) begin
                t_d = t_q + 1'b1;
            end else if (LOOP != 0) begin
                t_d     = '0;
                wraps_d = wraps_q + 8'(wraps_q != 8'hFF);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            t_q     <= '0;
            wraps_q <= '0;
        end else begin
            t_q     <= t_d;
            wraps_q <= wraps_d;
        end
    end

    // Channel k's slice starts at the MSB end; character i sits i bytes below its top.
    always_comb begin
        int unsigned msb;
        msb   = 0;
        sig_c = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            msb      = 8 * LENGTH * (CHANNELS - k) - 1 - 8 * 32'(t_q);
            sig_c[k] = (TRACES[msb -: 8] == 8'h2D);
        end
    end

    assign sig   = sig_c;
    assign t     = t_q;
    assign done  = (t_q == LAST);
    assign wraps = wraps_q;

`ifdef TRACE_SEQ_EDGE_EN
    logic [CHANNELS-1:0] prev_q;

    // prev tracks sig every edge regardless of enable, so a stall reads as "no edge".
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= sig_c;
        end
    end

    assign rose = reset ? '0 : (sig_c & ~prev_q);
    assign fell = reset ? '0 : (~sig_c & prev_q);
`else
    // Edge outputs and their history register are not built in this configuration.
`endif

endmodule
